// File: rtl/pll_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding,
// counter widths and a saturating increment helper.
package pll_pkg;

    // Sequencer states; the encoding is fixed so it can be probed externally.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } pll_state_t;

    // Width of the lock-loss event counter.
    localparam int LOSS_CNT_W = 8;

    // Width of the internal lock qualification counter.
    localparam int HOLD_CNT_W = 16;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] value);
        logic [LOSS_CNT_W-1:0] result;
        result = (value == {LOSS_CNT_W{1'b1}}) ? value : value + 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// All stages clear to 0 while resetn is low.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: synchronizes the PLL lock flag, qualifies it for
// HOLD_CYCLES consecutive cycles before releasing downstream reset, and
// reports lock losses.
// Optional feature: define PLL_RESET_SEQ_LOSS_COUNT_EN to build the
// saturating lock-loss counter and its clear_count input; otherwise
// loss_count is tied to 0 and clear_count is ignored.
module pll_reset_seq
    import pll_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  locked_in,
    input  logic                  clear_count,
    output logic                  sys_resetn,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    // Terminal count of the qualification counter.
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);

    logic                  w_locked_s;
    pll_state_t            r_state;
    pll_state_t            w_state_next;
    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic [HOLD_CNT_W-1:0] w_hold_cnt_next;

    // locked_in is asynchronous to clk; only the synchronized copy is used.
    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_sync_ff (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (locked_in),
        .o_q    (w_locked_s)
    );

    // State and qualification counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= WAIT_LOCK;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    // Next-state and counter logic; any loss of lock during HOLD restarts
    // qualification from zero.
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        case (r_state)
            WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_next    = HOLD;
                    w_hold_cnt_next = '0;
                end
            end
            HOLD: begin
                if (!w_locked_s) begin
                    w_state_next    = WAIT_LOCK;
                    w_hold_cnt_next = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next    = RUN;
                    w_hold_cnt_next = '0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_state_next = LOST;
                end
            end
            LOST: begin
                w_state_next = WAIT_LOCK;
            end
            default: begin
                w_state_next    = WAIT_LOCK;
                w_hold_cnt_next = '0;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset drops them
    // immediately and without glitches.
    assign sys_resetn = (r_state == RUN);
    assign ready      = (r_state == RUN);
    assign lock_lost  = (r_state == LOST);

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic                  w_lost_entry;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    assign w_lost_entry = (r_state == RUN) && !w_locked_s;

    // Saturating loss counter; a loss coinciding with a clear counts as the
    // first event after the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_loss_cnt <= '0;
        end else if (w_lost_entry) begin
            r_loss_cnt <= clear_count ? LOSS_CNT_W'(1) : sat_inc(r_loss_cnt);
        end else if (clear_count) begin
            r_loss_cnt <= '0;
        end
    end

    assign loss_count = r_loss_cnt;
`else
    logic w_unused_clear;

    assign w_unused_clear = clear_count;
    assign loss_count     = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq (SYNC_STAGES=2, HOLD_CYCLES=16).
// Works with and without PLL_RESET_SEQ_LOSS_COUNT_EN defined.
module tb_pll_reset_seq;
    import pll_pkg::*;

    localparam int SYNC     = 2;
    localparam int HOLD     = 16;
    localparam int RUN_EDGE = SYNC + HOLD + 1;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    localparam bit CNT_EN   = 1'b1;
    localparam int N_LOSSES = 300;
`else
    localparam bit CNT_EN   = 1'b0;
    localparam int N_LOSSES = 3;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       locked_in;
    logic       clear_count;
    logic       sys_resetn;
    logic       ready;
    logic       lock_lost;
    logic [7:0] loss_count;

    int n_vec  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    typedef struct {
        logic       li;
        logic       cc;
        logic       sr;
        logic       rdy;
        logic       ll;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pll_reset_seq #(
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .locked_in   (locked_in),
        .clear_count (clear_count),
        .sys_resetn  (sys_resetn),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .loss_count  (loss_count)
    );

    function automatic logic [7:0] cnt_val();
        return CNT_EN ? 8'(exp_cnt) : 8'd0;
    endfunction

    task automatic add(input logic li, input logic cc, input logic sr,
                       input logic rdy, input logic ll);
        vec_t v;
        v.li = li; v.cc = cc; v.sr = sr; v.rdy = rdy; v.ll = ll; v.cnt = cnt_val();
        vecs.push_back(v);
    endtask

    // From clean WAIT_LOCK: locked_in high, RUN at edge RUN_EDGE.
    task automatic gen_qualify();
        for (int e = 1; e < RUN_EDGE; e++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // From RUN: locked_in drops, LOST on the third edge, then WAIT_LOCK.
    task automatic gen_loss(input logic cc);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        if (cc) exp_cnt = 1;
        else if (exp_cnt < 255) exp_cnt = exp_cnt + 1;
        add(1'b0, cc, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_table();
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            locked_in   = vecs[i].li;
            clear_count = vecs[i].cc;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_vec++;
            if ({sys_resetn, ready, lock_lost, loss_count} !== {e.sr, e.rdy, e.ll, e.cnt}) begin
                n_fail++;
                $display("FAIL vec%0d: got sr=%b rdy=%b ll=%b cnt=%0d, want sr=%b rdy=%b ll=%b cnt=%0d",
                         i, sys_resetn, ready, lock_lost, loss_count, e.sr, e.rdy, e.ll, e.cnt);
            end
        end
        vecs.delete();
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if ({sys_resetn, ready, lock_lost, loss_count} !== 11'd0) begin
            n_fail++;
            $display("FAIL %s: got sr=%b rdy=%b ll=%b cnt=%0d, want all 0",
                     name, sys_resetn, ready, lock_lost, loss_count);
        end
    endtask

    initial begin
        int edges;
        resetn      = 1'b0;
        locked_in   = 1'b0;
        clear_count = 1'b0;
        #1;
        check_idle("reset_state");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Qualify then lose lock.
        gen_qualify();
        for (int e = 0; e < 5; e++) add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        gen_loss(1'b0);
        for (int e = 0; e < 3; e++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // One-cycle glitch at hold count 10 restarts qualification: RUN at 31.
        for (int e = 1; e <= 11; e++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 13; e <= 30; e++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        gen_loss(1'b0);

        // Plain clear while idle.
        exp_cnt = 0;
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Many losses to saturate, then a loss coinciding with clear.
        for (int n = 0; n < N_LOSSES; n++) begin
            gen_qualify();
            gen_loss(1'b0);
        end
        gen_qualify();
        gen_loss(1'b1);
        gen_qualify();
        apply_table();

        // Asynchronous reset in the middle of a RUN cycle.
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_idle("async_reset_now");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_idle("reset_held");
        end
        @(negedge clk);
        resetn = 1'b1;
        edges  = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            edges++;
            if (lock_lost !== 1'b0 || loss_count !== 8'd0) begin
                n_fail++;
                $display("FAIL requal_quiet: got ll=%b cnt=%0d, want ll=0 cnt=0", lock_lost, loss_count);
            end
            if (sys_resetn === 1'b1) break;
        end
        n_vec++;
        if (edges != RUN_EDGE || sys_resetn !== 1'b1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL requal_edge: got edge=%0d sr=%b rdy=%b, want edge=%0d sr=1 rdy=1",
                     edges, sys_resetn, ready, RUN_EDGE);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on locked_in (legal 2..4).
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024, consecutive synchronized-locked cycles required before release (legal 2..65535).
REQ-003 SHALL have port clk  input  1  PLL output clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port locked_in  input  1  PLL lock indication, asynchronous to clk.
REQ-006 SHALL have port clear_count  input  1  synchronous clear of loss_count.
REQ-007 SHALL have port sys_resetn  output  1  active-low reset for downstream logic.
REQ-008 SHALL have port ready  output  1  high while clock is qualified.
REQ-009 SHALL have port lock_lost  output  1  one-cycle pulse on loss of lock.
REQ-010 SHALL have port loss_count  output  8  saturating count of lock-loss events.

Function
REQ-011 SHALL pass locked_in through SYNC_STAGES flops; the last stage is locked_s, the only internal use of lock.
REQ-012 SHALL implement states WAIT_LOCK, HOLD, RUN, LOST in a state register; sys_resetn and ready decode directly from that register.
REQ-013 WAIT_LOCK: sys_resetn=0, ready=0; locked_s=1 -> HOLD with hold counter loaded to 0.
REQ-014 HOLD: counter increments each cycle while locked_s=1; locked_s=0 -> WAIT_LOCK immediately, counter discarded; counter==HOLD_CYCLES-1 -> RUN on next edge.
REQ-015 RUN: sys_resetn=1, ready=1; locked_s=0 -> LOST.
REQ-016 LOST: sys_resetn=0, ready=0, lock_lost=1 for exactly this one cycle; unconditionally -> WAIT_LOCK.
REQ-017 With locked_in held high from a clean WAIT_LOCK, RUN SHALL be entered exactly SYNC_STAGES+HOLD_CYCLES+1 rising edges after locked_in rises (setup met).
REQ-018 A locked_s glitch of a single cycle low in HOLD SHALL restart the full HOLD_CYCLES qualification.
REQ-019 Hold counter SHALL be 16 bits and SHALL never wrap; it is only compared, never exposed.
REQ-020 loss_count SHALL increment by 1 on each LOST entry and saturate at 255.
REQ-021 clear_count and a LOST entry in the same cycle SHALL yield loss_count=1.
REQ-022 lock_lost SHALL never assert outside LOST; no pulse on WAIT_LOCK or HOLD aborts.

Reset
REQ-023 resetn low SHALL asynchronously force state=WAIT_LOCK, synchronizer flops=0, hold counter=0, loss_count=0, sys_resetn=0, ready=0, lock_lost=0.
REQ-024 Reset asserted mid-RUN SHALL drop sys_resetn in the same instant without a lock_lost pulse or loss_count change.
REQ-025 After resetn release the block SHALL requalify lock from scratch per REQ-017.

Configuration
REQ-026 Macro PLL_RESET_SEQ_LOSS_COUNT_EN defined: loss counter and clear_count logic SHALL be present per REQ-020/021.
REQ-027 Macro undefined: loss_count SHALL be constant 0, clear_count SHALL be ignored; all other behaviour unchanged.

Structure
REQ-028 State encodings (WAIT_LOCK=0, HOLD=1, RUN=2, LOST=3) and loss counter width (8) SHALL live in shared package pll_pkg.
REQ-029 Synchronizer SHALL be sub-module sync_ff (parameterized depth, async active-low reset to 0); no other sub-modules.

Verification (bench uses HOLD_CYCLES=16, SYNC_STAGES=2)
REQ-030 locked_in 0->1 after reset, held -> sys_resetn and ready rise at edge 19, lock_lost stays 0.
REQ-031 In RUN drop locked_in -> LOST entered 3 edges later, lock_lost high one cycle, loss_count 0->1, sys_resetn=0 from that cycle.
REQ-032 In HOLD pull locked_in low one cycle at count 10 -> WAIT_LOCK, then RUN only 16 qualified cycles after locked_s returns high.
REQ-033 Force 300 lock losses -> loss_count saturates at 255; clear_count coincident with a loss -> loss_count=1.
REQ-034 resetn asserted mid-RUN -> sys_resetn=0 asynchronously, loss_count=0, no lock_lost pulse; release with locked_in high -> RUN at edge 19.
REQ-035 Build without PLL_RESET_SEQ_LOSS_COUNT_EN, repeat REQ-031 -> loss_count stays 0, lock_lost still pulses.
